// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational adder/flag ALU between two requesters.
// Requests are granted round-robin. The winner's operands are registered onto
// the ALU inputs, the sum and flags are captured one cycle later, and the
// result is returned to the winner through a valid/ready response handshake.
module alu_arbiter #(
   parameter int WIDTH = 64
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             a_valid_i,
   output logic             a_ready_o,
   input  logic [WIDTH-1:0] a_inA_i,
   input  logic [WIDTH-1:0] a_inB_i,
   input  logic             b_valid_i,
   output logic             b_ready_o,
   input  logic [WIDTH-1:0] b_inA_i,
   input  logic [WIDTH-1:0] b_inB_i,
   output logic             a_rsp_valid_o,
   input  logic             a_rsp_ready_i,
   output logic             b_rsp_valid_o,
   input  logic             b_rsp_ready_i,
   output logic [WIDTH-1:0] out_o,
   output logic             vflag_o,
   output logic             cflag_o,
   output logic             zflag_o,
   output logic             busy_o,
   output logic [WIDTH-1:0] alu_inA_o,
   output logic [WIDTH-1:0] alu_inB_o,
   input  logic [WIDTH-1:0] alu_out_i,
   input  logic             alu_vflag_i,
   input  logic             alu_cflag_i,
   input  logic             alu_zflag_i
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t state;
   logic   owner;       // requester holding the ALU: 0 = A, 1 = B
   logic   last_grant;  // requester granted most recently: 0 = A, 1 = B
   logic   grant_a;
   logic   grant_b;
   logic   owner_rsp_ready;

   // Round-robin grant, offered only while idle; a lone requester always wins,
   // a tie goes to whichever side was not granted last. Held off during reset.
   always_comb begin
      grant_a = 1'b0;
      grant_b = 1'b0;
      if (state == IDLE && reset_i) begin
         grant_a = a_valid_i & (last_grant | ~b_valid_i);
         grant_b = b_valid_i & (~last_grant | ~a_valid_i);
      end
   end

   assign a_ready_o       = grant_a;
   assign b_ready_o       = grant_b;
   assign busy_o          = (state != IDLE);
   // Only the owner's consume strobe matters; the other side's is ignored.
   assign owner_rsp_ready = owner ? b_rsp_ready_i : a_rsp_ready_i;

   // Sequencer: issue operands, capture ALU result, hold it until consumed.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state         <= IDLE;
         owner         <= 1'b0;
         last_grant    <= 1'b1;
         alu_inA_o     <= '0;
         alu_inB_o     <= '0;
         out_o         <= '0;
         vflag_o       <= 1'b0;
         cflag_o       <= 1'b0;
         zflag_o       <= 1'b0;
         a_rsp_valid_o <= 1'b0;
         b_rsp_valid_o <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_a || grant_b) begin
                  alu_inA_o  <= grant_b ? b_inA_i : a_inA_i;
                  alu_inB_o  <= grant_b ? b_inB_i : a_inB_i;
                  owner      <= grant_b;
                  last_grant <= grant_b;
                  state      <= EXEC;
               end
            end
            EXEC: begin
               out_o         <= alu_out_i;
               vflag_o       <= alu_vflag_i;
               cflag_o       <= alu_cflag_i;
               zflag_o       <= alu_zflag_i;
               a_rsp_valid_o <= ~owner;
               b_rsp_valid_o <= owner;
               state         <= RESP;
            end
            RESP: begin
               if (owner_rsp_ready) begin
                  a_rsp_valid_o <= 1'b0;
                  b_rsp_valid_o <= 1'b0;
                  state         <= IDLE;
               end
            end
            default: begin
               a_rsp_valid_o <= 1'b0;
               b_rsp_valid_o <= 1'b0;
               state         <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: a behavioural ALU drives the DUT's ALU port, a
// scoreboard queue holds the expected response of every granted operation,
// and a negedge monitor checks arbitration, latency, busy and response data.
module tb_alu_arbiter;

   localparam int W = 64;

   logic         clk = 1'b0;
   logic         reset_i = 1'b1;
   logic         a_valid = 1'b0, b_valid = 1'b0;
   logic         a_ready, b_ready;
   logic [W-1:0] a_inA = '0, a_inB = '0, b_inA = '0, b_inB = '0;
   logic         a_rsp_valid, b_rsp_valid;
   logic         a_rsp_ready = 1'b1, b_rsp_ready = 1'b1;
   logic [W-1:0] out;
   logic         vflag, cflag, zflag, busy;
   logic [W-1:0] alu_inA, alu_inB, alu_out;
   logic         alu_v, alu_c, alu_z;
   logic [W:0]   alu_wide;

   int checks = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   // Behavioural adder standing in for the shared ALU
   assign alu_wide = {1'b0, alu_inA} + {1'b0, alu_inB};
   assign alu_out  = alu_wide[W-1:0];
   assign alu_c    = alu_wide[W];
   assign alu_v    = (alu_inA[W-1] == alu_inB[W-1]) && (alu_out[W-1] != alu_inA[W-1]);
   assign alu_z    = (alu_out == '0);

   alu_arbiter #(.WIDTH(W)) dut (
      .clk_i(clk), .reset_i(reset_i),
      .a_valid_i(a_valid), .a_ready_o(a_ready), .a_inA_i(a_inA), .a_inB_i(a_inB),
      .b_valid_i(b_valid), .b_ready_o(b_ready), .b_inA_i(b_inA), .b_inB_i(b_inB),
      .a_rsp_valid_o(a_rsp_valid), .a_rsp_ready_i(a_rsp_ready),
      .b_rsp_valid_o(b_rsp_valid), .b_rsp_ready_i(b_rsp_ready),
      .out_o(out), .vflag_o(vflag), .cflag_o(cflag), .zflag_o(zflag), .busy_o(busy),
      .alu_inA_o(alu_inA), .alu_inB_o(alu_inB), .alu_out_i(alu_out),
      .alu_vflag_i(alu_v), .alu_cflag_i(alu_c), .alu_zflag_i(alu_z)
   );

   typedef struct packed {
      logic         port;
      logic [W-1:0] sum;
      logic         v;
      logic         c;
      logic         z;
   } exp_t;

   exp_t q[$];

   // Reference result: unsigned sum modulo 2^W, carry out, signed overflow
   // from a sign-extended sum, zero on the wrapped sum.
   function automatic exp_t ref_op(input logic p, input logic [W-1:0] x, input logic [W-1:0] y);
      exp_t             e;
      logic [W:0]       uu;
      logic signed [W:0] ss;
      uu = {1'b0, x} + {1'b0, y};
      ss = $signed({x[W-1], x}) + $signed({y[W-1], y});
      e.port = p;
      e.sum  = uu[W-1:0];
      e.c    = uu[W];
      e.v    = ss[W] ^ ss[W-1];
      e.z    = (uu[W-1:0] == '0);
      return e;
   endfunction

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard / protocol model state
   logic         pend = 1'b0;
   logic         own = 1'b0;
   logic         last_b = 1'b1;
   int           gcyc = 0;
   int           cyc = 0;
   logic [W-1:0] gx = '0, gy = '0;

   // Monitor: model arbitration and response timing, compare with the DUT
   always @(negedge clk) begin
      logic   p0;
      logic [1:0] er;
      logic [1:0] erv;
      logic   win_b;
      if (!reset_i) begin
         chk("reset_outputs",
             {a_ready, b_ready, a_rsp_valid, b_rsp_valid, busy, out, vflag, cflag, zflag, alu_inA, alu_inB},
             '0);
         q.delete();
         pend   = 1'b0;
         last_b = 1'b1;
      end else begin
         p0 = pend;
         chk("busy", busy, p0);
         if (a_ready && b_ready) begin
            fails++;
            $display("FAIL both_ready: got 11 expected at most one");
         end
         er = 2'b00;
         if (!p0) begin
            if (a_valid && b_valid) er = last_b ? 2'b10 : 2'b01;
            else                    er = {a_valid, b_valid};
         end
         chk("grant", {a_ready, b_ready}, er);
         if (p0 && cyc == gcyc + 1)
            chk("alu_operands", {alu_inA, alu_inB}, {gx, gy});
         erv = 2'b00;
         if (p0 && cyc >= gcyc + 2) erv = own ? 2'b01 : 2'b10;
         chk("rsp_valid", {a_rsp_valid, b_rsp_valid}, erv);
         if (a_rsp_valid || b_rsp_valid) begin
            if (q.size() == 0) begin
               fails++;
               $display("FAIL rsp_unexpected: got response expected none");
            end else begin
               chk("rsp_data", {out, vflag, cflag, zflag}, {q[0].sum, q[0].v, q[0].c, q[0].z});
            end
         end
         if (p0 && cyc >= gcyc + 2 && (own ? b_rsp_ready : a_rsp_ready)) begin
            if (q.size() > 0) void'(q.pop_front());
            pend = 1'b0;
         end
         if (!p0 && (a_ready || b_ready)) begin
            win_b = b_ready;
            gx    = win_b ? b_inA : a_inA;
            gy    = win_b ? b_inB : a_inB;
            q.push_back(ref_op(win_b, gx, gy));
            pend   = 1'b1;
            own    = win_b;
            last_b = win_b;
            gcyc   = cyc;
         end
      end
      cyc++;
   end

   function automatic logic [W-1:0] rand_op();
      case ($urandom_range(0, 4))
         0:       return '1;
         1:       return {1'b1, {(W-1){1'b0}}};
         2:       return '0;
         3:       return {1'b0, {(W-1){1'b1}}};
         default: return {$urandom, $urandom};
      endcase
   endfunction

   task automatic run_a(input int n, input bit rnd, input logic [W-1:0] x, input logic [W-1:0] y);
      int t;
      for (int i = 0; i < n; i++) begin
         if (rnd) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            a_inA = rand_op();
            a_inB = rand_op();
         end else begin
            a_inA = x;
            a_inB = y;
         end
         a_valid = 1'b1;
         t = 0;
         do begin @(negedge clk); t++; end while (!a_ready && t < 200);
         if (!a_ready) begin
            fails++;
            $display("FAIL a_ready_timeout: got 0 expected 1");
         end
         @(posedge clk); #1;
         a_valid = 1'b0;
      end
   endtask

   task automatic run_b(input int n, input bit rnd, input logic [W-1:0] x, input logic [W-1:0] y);
      int t;
      for (int i = 0; i < n; i++) begin
         if (rnd) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            b_inA = rand_op();
            b_inB = rand_op();
         end else begin
            b_inA = x;
            b_inB = y;
         end
         b_valid = 1'b1;
         t = 0;
         do begin @(negedge clk); t++; end while (!b_ready && t < 200);
         if (!b_ready) begin
            fails++;
            $display("FAIL b_ready_timeout: got 0 expected 1");
         end
         @(posedge clk); #1;
         b_valid = 1'b0;
      end
   endtask

   task automatic expect_a(input string name, input logic [W+2:0] exp);
      int t = 0;
      do begin @(negedge clk); t++; end while (!a_rsp_valid && t < 20);
      chk(name, {out, vflag, cflag, zflag}, exp);
   endtask

   task automatic wait_idle();
      int t = 0;
      do begin @(negedge clk); t++; end
      while ((busy || q.size() != 0 || a_valid || b_valid) && t < 100);
      if (busy || q.size() != 0) begin
         fails++;
         $display("FAIL idle_timeout: got busy=%0d queued=%0d expected idle", busy, q.size());
      end
      @(posedge clk); #1;
   endtask

   bit done = 1'b0;

   initial begin
      // Reset with both requesters pending
      #1;
      reset_i = 1'b0;
      a_valid = 1'b1; a_inA = 64'h4000_0000_0000_0000; a_inB = 64'h4000_0000_0000_0000;
      b_valid = 1'b1; b_inA = 64'h8000_0000_0000_0000; b_inB = 64'h8000_0000_0000_0000;
      repeat (2) @(posedge clk);
      #1;
      reset_i = 1'b1;

      // Continuous contention: grants alternate A,B,A,B
      fork
         run_a(2, 1'b0, 64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000);
         run_b(2, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
      join
      wait_idle();

      // A alone, 1 + 1
      run_a(1, 1'b0, 64'h1, 64'h1);
      expect_a("a_one_plus_one", {64'h2, 3'b000});
      wait_idle();

      // Backpressure on A with B waiting, B's rsp_ready high on the wrong port
      a_rsp_ready = 1'b0;
      b_rsp_ready = 1'b1;
      fork
         run_a(1, 1'b0, 64'h1234_5678_9abc_def0, 64'h0fed_cba9_8765_4321);
         begin
            @(posedge clk); #1;
            run_b(1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1);
         end
         begin
            int t = 0;
            do begin @(negedge clk); t++; end while (!a_rsp_valid && t < 20);
            repeat (5) @(negedge clk);
            @(posedge clk); #1;
            a_rsp_ready = 1'b1;
         end
      join
      wait_idle();

      // Reset while an operation is in EXEC, then a fresh request
      a_inA = 64'h5; a_inB = 64'h5; a_valid = 1'b1;
      begin
         int t = 0;
         do begin @(negedge clk); t++; end while (!a_ready && t < 20);
      end
      @(posedge clk); #1;
      a_valid = 1'b0;
      reset_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset_i = 1'b1;
      run_a(1, 1'b0, 64'h2, 64'h2);
      expect_a("a_after_reset", {64'h4, 3'b000});
      wait_idle();

      // Randomised traffic with random response backpressure
      fork
         begin
            fork
               run_a(40, 1'b1, '0, '0);
               run_b(40, 1'b1, '0, '0);
            join
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk); #1;
               a_rsp_ready = ($urandom_range(0, 3) != 0);
               b_rsp_ready = ($urandom_range(0, 3) != 0);
            end
            a_rsp_ready = 1'b1;
            b_rsp_ready = 1'b1;
         end
      join
      wait_idle();

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares the single combinational 64-bit ALU (adder with V/C/Z flags) between two requesters, A and B. Requests are granted round-robin. The block registers the winner's operands onto the ALU inputs, captures the sum and flags one cycle later, and returns the result to the winner through a valid/ready response handshake. It sits between the instruction-sequencing logic (port A) and the address-generation logic (port B) and the `alu` instance.

Parameters:
WIDTH, 64, operand/result width; must match the ALU.

Ports:
clk_i  in  1  clock; all state changes on rising edge.
reset_i  in  1  reset, asynchronous assert, active-low; synchronous deassert is the system's responsibility.
a_valid_i  in  1  requester A has an operation pending.
a_ready_o  out  1  A's operation accepted this cycle.
a_inA_i, a_inB_i  in  WIDTH  A's operands.
b_valid_i  in  1  requester B has an operation pending.
b_ready_o  out  1  B's operation accepted this cycle.
b_inA_i, b_inB_i  in  WIDTH  B's operands.
a_rsp_valid_o  out  1  result on out_o/flags belongs to A.
a_rsp_ready_i  in  1  A consumes the result.
b_rsp_valid_o  out  1  result belongs to B.
b_rsp_ready_i  in  1  B consumes the result.
out_o  out  WIDTH  registered sum.
vflag_o, cflag_o, zflag_o  out  1 each  registered overflow, carry and zero flags.
busy_o  out  1  high in any state except IDLE.
alu_inA_o, alu_inB_o  out  WIDTH  registered operands to the ALU.
alu_out_i  in  WIDTH  ALU sum.
alu_vflag_i, alu_cflag_i, alu_zflag_i  in  1 each  ALU flags.

Behaviour:
- Reset (reset_i low, asynchronous):
  - state=IDLE; priority=A (last_grant=B).
  - All *_ready_o, *_rsp_valid_o and busy_o are 0.
  - out_o, all flags and alu_in*_o are 0.
  - An in-flight operation or unconsumed response is discarded; no response is ever issued for it.
- States: IDLE, EXEC, RESP.
- IDLE:
  - a_ready_o = a_valid_i & (prio==A | ~b_valid_i).
  - b_ready_o = b_valid_i & (prio==B | ~a_valid_i).
  - At most one ready is high in any cycle; ready is 0 in every other state.
  - On handshake: winner's operands go to alu_inA_o/alu_inB_o, owner<=winner, last_grant<=winner, go to EXEC.
  - No valid: stay in IDLE, alu_in*_o hold their values.
- EXEC (exactly 1 cycle): alu_out_i and the flags are captured into out_o/*flag_o; go to RESP.
- RESP:
  - The owner's rsp_valid_o is 1 and the other's is 0.
  - out_o and flags are held stable until the owner's rsp_ready_i is sampled high; then rsp_valid drops and state returns to IDLE.
  - The non-owner's rsp_ready_i is ignored.
- Latency: handshake in cycle N -> rsp_valid high in cycle N+2. Minimum initiation interval is 3 cycles (IDLE, EXEC, RESP with immediate ready).
- Round robin:
  - With simultaneous valids, the requester not granted last wins.
  - The first tie after reset goes to A.
  - A lone requester is always granted, regardless of priority.
- Requests arriving during EXEC/RESP wait; requesters must hold valid and operands stable until ready.
- Arithmetic: no modification of ALU results. The WIDTH-bit sum wraps modulo 2^WIDTH; C, V and Z are passed through exactly as the ALU produces them.
- rsp_valid never rises in the same cycle as any *_ready_o.

Test Plan:
1. Reset sequence: reset_i low for 2 cycles with both valids high -> all ready/rsp_valid/busy 0 and out_o=0. After release, A is granted first.
2. A alone, inA=inB=64'h0000_0000_0000_0001, a_rsp_ready_i=1 -> a_ready at N; a_rsp_valid at N+2 with out_o=64'h2 and V=C=Z=0; busy at N+1..N+2; b_rsp_valid stays 0.
3. Both valid every cycle (A: 64'h4000_0000_0000_0000 twice; B: 64'h8000_0000_0000_0000 twice):
   - Grants alternate A,B,A,B.
   - A responses: out_o=64'h8000_0000_0000_0000, C=0, V=1, Z=0.
   - B responses: out_o=0, C=1, V=1, Z=1.
4. Backpressure: A's rsp_ready held 0 for 5 cycles -> a_rsp_valid and out_o stay stable; b_valid held high is not granted. On the cycle after ready, IDLE grants B.
5. Wrong-port ready: B's rsp_ready=1 while A owns the response -> no effect; the response stays valid.
6. Reset mid-op: assert reset_i during EXEC -> outputs clear immediately with no response. After release, a fresh request completes normally with 64'h2+64'h2 -> 64'h4.
